// File: rtl/bvh_traverse_ctrl.sv
// Depth-first BVH traversal controller: walks nodes with an explicit stack, delegates
// box tests over a valid/ready handshake and streams hit-leaf triangle indices.
module bvh_traverse_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 32,
    parameter int MEM_LAT     = 1,
    parameter int NODE_WORDS  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] root_ptr,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              box_req_valid,
    input  logic              box_req_ready,
    output logic [ADDR_W-1:0] box_req_ptr,
    input  logic              box_rsp_valid,
    input  logic              box_hit,
    output logic              leaf_valid,
    input  logic              leaf_ready,
    output logic [DATA_W-1:0] leaf_tri,
    output logic [15:0]       nodes_visited,
    output logic [3:0]        dbg_state
);
    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // the producer holds valid and its payload stable until that cycle.
    localparam int SP_W      = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W     = $clog2(STACK_DEPTH);
    localparam int FC_W      = $clog2(MEM_LAT + 3);
    localparam int TRI_OFF   = NODE_WORDS - 3;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(MEM_LAT + 2);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_BOX_REQ, S_BOX_WAIT, S_FETCH, S_DECIDE, S_EMIT, S_POP, S_DONE, S_ERR
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cur, left_q, right_q;
    logic [DATA_W-1:0]   tri_q;
    logic [SP_W-1:0]     sp;
    logic [FC_W-1:0]     fcnt;
    logic [ADDR_W-1:0]   stack [STACK_DEPTH];
    logic [IDX_W-1:0]    top_idx;
    logic                is_leaf;
    logic                do_push;

    assign dbg_state = state;
    assign top_idx   = IDX_W'(sp - SP_W'(1));
    assign is_leaf   = (tri_q != '1);
    assign do_push   = (state == S_DECIDE) && !is_leaf && (sp != SP_FULL);

    always_comb begin
        state_n       = state;
        busy          = 1'b0;
        done          = 1'b0;
        mem_rd_en     = 1'b0;
        mem_addr      = '0;
        box_req_valid = 1'b0;
        box_req_ptr   = '0;
        leaf_valid    = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = S_BOX_REQ;
            S_BOX_REQ: begin
                busy          = 1'b1;
                box_req_valid = 1'b1;
                box_req_ptr   = cur;
                if (box_req_ready) state_n = S_BOX_WAIT;
            end
            S_BOX_WAIT: begin
                busy = 1'b1;
                if (box_rsp_valid) state_n = box_hit ? S_FETCH : S_POP;
            end
            S_FETCH: begin
                busy = 1'b1;
                // First three cycles issue tri/left/right reads; captures trail by MEM_LAT.
                if (fcnt < FC_W'(3)) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = cur + ADDR_W'(TRI_OFF) + ADDR_W'(fcnt);
                end
                if (fcnt == FC_LAST) state_n = S_DECIDE;
            end
            S_DECIDE: begin
                busy = 1'b1;
                if (is_leaf)              state_n = S_EMIT;
                else if (sp == SP_FULL)   state_n = S_ERR;
                else                      state_n = S_BOX_REQ;
            end
            S_EMIT: begin
                busy       = 1'b1;
                leaf_valid = 1'b1;
                if (leaf_ready) state_n = S_POP;
            end
            S_POP: begin
                busy    = 1'b1;
                state_n = (sp == '0) ? S_DONE : S_BOX_REQ;
            end
            S_DONE, S_ERR: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cur           <= '0;
            sp            <= '0;
            fcnt          <= '0;
            tri_q         <= '0;
            left_q        <= '0;
            right_q       <= '0;
            leaf_tri      <= '0;
            nodes_visited <= '0;
            overflow      <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (start) begin
                    cur           <= root_ptr;
                    sp            <= '0;
                    nodes_visited <= '0;
                    overflow      <= 1'b0;
                end
                S_BOX_REQ: if (box_req_ready && nodes_visited != 16'hFFFF)
                    nodes_visited <= nodes_visited + 16'd1;
                S_BOX_WAIT: fcnt <= '0;
                S_FETCH: begin
                    fcnt <= fcnt + FC_W'(1);
                    if (fcnt == FC_W'(MEM_LAT))     tri_q   <= mem_rdata;
                    if (fcnt == FC_W'(MEM_LAT + 1)) left_q  <= mem_rdata[ADDR_W-1:0];
                    if (fcnt == FC_LAST)            right_q <= mem_rdata[ADDR_W-1:0];
                end
                S_DECIDE: begin
                    if (is_leaf) begin
                        leaf_tri <= tri_q;
                    end else if (sp == SP_FULL) begin
                        overflow <= 1'b1;
                    end else begin
                        sp  <= sp + SP_W'(1);
                        cur <= left_q;
                    end
                end
                S_POP: if (sp != '0) begin
                    sp  <= sp - SP_W'(1);
                    cur <= stack[top_idx];
                end
                default: ;
            endcase
        end
    end

    // Stack storage carries no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) stack[sp[IDX_W-1:0]] <= right_q;
    end

endmodule

// File: tb/tb_bvh_traverse_ctrl.sv
// Directed bench for bvh_traverse_ctrl: default instance (MEM_LAT=1) plus a
// STACK_DEPTH=2 / MEM_LAT=3 instance, each with its own memory and box-unit models.
module tb_bvh_traverse_ctrl;
    localparam int AW = 18;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [DW-1:0] mem  [256];
    logic          miss [256];
    int n_cmp = 0;
    int n_err = 0;

    logic start_a, start_b;
    logic [AW-1:0] root_a, root_b;
    logic busy_a, done_a, ovf_a, rd_a, busy_b, done_b, ovf_b, rd_b;
    logic [AW-1:0] addr_a, addr_b, breq_p_a, breq_p_b;
    logic [DW-1:0] rdata_a, rdata_b, leaf_tri_a, leaf_tri_b;
    logic breq_v_a, breq_r_a, brsp_v_a, bhit_a, leaf_v_a, leaf_r_a;
    logic breq_v_b, breq_r_b, brsp_v_b, bhit_b, leaf_v_b, leaf_r_b;
    logic [15:0] nv_a, nv_b;
    logic [3:0] st_a, st_b;

    bvh_traverse_ctrl u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .root_ptr(root_a), .busy(busy_a),
        .done(done_a), .overflow(ovf_a), .mem_rd_en(rd_a), .mem_addr(addr_a),
        .mem_rdata(rdata_a), .box_req_valid(breq_v_a), .box_req_ready(breq_r_a),
        .box_req_ptr(breq_p_a), .box_rsp_valid(brsp_v_a), .box_hit(bhit_a),
        .leaf_valid(leaf_v_a), .leaf_ready(leaf_r_a), .leaf_tri(leaf_tri_a),
        .nodes_visited(nv_a), .dbg_state(st_a)
    );

    bvh_traverse_ctrl #(.STACK_DEPTH(2), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .root_ptr(root_b), .busy(busy_b),
        .done(done_b), .overflow(ovf_b), .mem_rd_en(rd_b), .mem_addr(addr_b),
        .mem_rdata(rdata_b), .box_req_valid(breq_v_b), .box_req_ready(breq_r_b),
        .box_req_ptr(breq_p_b), .box_rsp_valid(brsp_v_b), .box_hit(bhit_b),
        .leaf_valid(leaf_v_b), .leaf_ready(leaf_r_b), .leaf_tri(leaf_tri_b),
        .nodes_visited(nv_b), .dbg_state(st_b)
    );

    // Memory models: data is only meaningful exactly MEM_LAT cycles after a read.
    logic [DW-1:0] pb1, pb2;
    always @(posedge clk) begin
        rdata_a <= rd_a ? mem[addr_a[7:0]] : 32'hDEAD_BEEF;
        pb1     <= rd_b ? mem[addr_b[7:0]] : 32'hDEAD_BEEF;
        pb2     <= pb1;
        rdata_b <= pb2;
    end

    // Box-unit models: ready after bd_* stalled cycles, response two cycles later.
    int bd_a, bd_b, bw_a, bw_b;
    int hs_a = 0;
    int hs_b = 0;
    logic [1:0] rc_a, rc_b;
    logic [AW-1:0] rp_a, rp_b;
    assign breq_r_a = breq_v_a && (bw_a >= bd_a);
    assign breq_r_b = breq_v_b && (bw_b >= bd_b);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bw_a <= 0; rc_a <= 2'd0; rp_a <= '0; brsp_v_a <= 1'b0; bhit_a <= 1'b0;
        end else begin
            brsp_v_a <= 1'b0;
            bhit_a   <= 1'b0;
            bw_a     <= (breq_v_a && !breq_r_a) ? bw_a + 1 : 0;
            if (breq_v_a && breq_r_a) begin
                rc_a <= 2'd2; rp_a <= breq_p_a; hs_a <= hs_a + 1;
            end else if (rc_a != 2'd0) begin
                rc_a <= rc_a - 2'd1;
                if (rc_a == 2'd1) begin brsp_v_a <= 1'b1; bhit_a <= !miss[rp_a[7:0]]; end
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bw_b <= 0; rc_b <= 2'd0; rp_b <= '0; brsp_v_b <= 1'b0; bhit_b <= 1'b0;
        end else begin
            brsp_v_b <= 1'b0;
            bhit_b   <= 1'b0;
            bw_b     <= (breq_v_b && !breq_r_b) ? bw_b + 1 : 0;
            if (breq_v_b && breq_r_b) begin
                rc_b <= 2'd2; rp_b <= breq_p_b; hs_b <= hs_b + 1;
            end else if (rc_b != 2'd0) begin
                rc_b <= rc_b - 2'd1;
                if (rc_b == 2'd1) begin brsp_v_b <= 1'b1; bhit_b <= !miss[rp_b[7:0]]; end
            end
        end
    end

    // Scoreboard capture of accepted leaves and done pulses.
    logic [DW-1:0] got_a [$];
    logic [DW-1:0] got_b [$];
    int dcnt_a = 0;
    int dcnt_b = 0;
    always @(posedge clk) begin
        if (!reset && leaf_v_a && leaf_r_a) got_a.push_back(leaf_tri_a);
        if (!reset && leaf_v_b && leaf_r_b) got_b.push_back(leaf_tri_b);
        if (!reset && done_a) dcnt_a <= dcnt_a + 1;
        if (!reset && done_b) dcnt_b <= dcnt_b + 1;
    end

    task automatic set_node(input int a, input logic [DW-1:0] t, input int l, input int r);
        mem[a+6] = t; mem[a+7] = DW'(l); mem[a+8] = DW'(r);
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) begin mem[i] = '0; miss[i] = 1'b0; end
        set_node(0,  32'hFFFF_FFFF, 9, 18);   // complete 3-level tree, leaves 27..54
        set_node(9,  32'hFFFF_FFFF, 27, 36);
        set_node(18, 32'hFFFF_FFFF, 45, 54);
        set_node(27, 32'd0, 0, 0);
        set_node(36, 32'd1, 0, 0);
        set_node(45, 32'd2, 0, 0);
        set_node(54, 32'd3, 0, 0);
        set_node(63, 32'd5, 0, 0);            // single-leaf root
        set_node(72, 32'hFFFF_FFFF, 81, 117); // left-degenerate chain of depth 4
        set_node(81, 32'hFFFF_FFFF, 90, 117);
        set_node(90, 32'hFFFF_FFFF, 99, 117);
        set_node(99, 32'd7, 0, 0);
        set_node(117, 32'd9, 0, 0);
    endtask

    task automatic go_a(input logic [AW-1:0] r);
        @(negedge clk); root_a = r; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic go_b(input logic [AW-1:0] r);
        @(negedge clk); root_b = r; start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
    endtask

    task automatic wait_done_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (done_b) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy_a, done_a, ovf_a, rd_a, breq_v_a, leaf_v_a} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctl_a: got %b want 000000",
                              {busy_a, done_a, ovf_a, rd_a, breq_v_a, leaf_v_a});
        end
        n_cmp++;
        if ({addr_a, breq_p_a, leaf_tri_a, nv_a, st_a} !== '0) begin
            n_err++; $display("FAIL reset_data_a: addr %0h ptr %0h tri %0h nv %0d st %0d want all 0",
                              addr_a, breq_p_a, leaf_tri_a, nv_a, st_a);
        end
        n_cmp++;
        if ({busy_b, done_b, ovf_b, rd_b, breq_v_b, leaf_v_b, nv_b} !== '0) begin
            n_err++; $display("FAIL reset_b: ctl %b nv %0d want 0",
                              {busy_b, done_b, ovf_b, rd_b, breq_v_b, leaf_v_b}, nv_b);
        end
    endtask

    task automatic test_single_leaf();
        int base = got_a.size();
        int d0 = dcnt_a;
        bit ok;
        leaf_r_a = 1'b1;
        go_a(63);
        n_cmp++;
        if ({busy_a, breq_v_a, breq_p_a} !== {1'b1, 1'b1, AW'(63)}) begin
            n_err++; $display("FAIL single_req: busy %b valid %b ptr %0d want 1 1 63",
                              busy_a, breq_v_a, breq_p_a);
        end
        wait_done_a(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_done: got timeout want done"); end
        n_cmp++;
        if (got_a.size() != base + 1 || got_a[base] !== 32'd5) begin
            n_err++; $display("FAIL single_leaf: got %0d leaves want one leaf 5", got_a.size() - base);
        end
        n_cmp++;
        if (nv_a !== 16'd1 || ovf_a !== 1'b0) begin
            n_err++; $display("FAIL single_nv: got nv %0d ovf %b want 1 0", nv_a, ovf_a);
        end
        @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || dcnt_a - d0 != 1) begin
            n_err++; $display("FAIL single_pulse: done %b busy %b pulses %0d want 0 0 1",
                              done_a, busy_a, dcnt_a - d0);
        end
    endtask

    task automatic test_root_miss();
        int base = got_a.size();
        bit ok;
        miss[63] = 1'b1;
        go_a(63);
        wait_done_a(ok);
        miss[63] = 1'b0;
        n_cmp++;
        if (!ok || got_a.size() != base || nv_a !== 16'd1) begin
            n_err++; $display("FAIL root_miss: done %b leaves %0d nv %0d want 1 0 1",
                              ok, got_a.size() - base, nv_a);
        end
    endtask

    task automatic test_full_tree();
        int base = got_a.size();
        bit ok;
        go_a(0);
        wait_done_a(ok);
        n_cmp++;
        if (!ok || got_a.size() != base + 4) begin
            n_err++; $display("FAIL tree_count: done %b leaves %0d want 1 4", ok, got_a.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (base + i >= got_a.size() || got_a[base+i] !== DW'(i)) begin
                n_err++; $display("FAIL tree_leaf%0d: leaf missing or wrong, want %0d", i, i);
            end
        end
        n_cmp++;
        if (nv_a !== 16'd7) begin n_err++; $display("FAIL tree_nv: got %0d want 7", nv_a); end
    endtask

    task automatic test_left_miss_stall();
        int base = got_a.size();
        int exp_l [2] = '{2, 3};
        bit ok, seen, unstable;
        miss[9] = 1'b1;
        leaf_r_a = 1'b0;
        go_a(0);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = leaf_v_a;
        end
        unstable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (leaf_v_a !== 1'b1 || leaf_tri_a !== 32'd2) unstable = 1'b1;
        end
        n_cmp++;
        if (!seen || unstable || got_a.size() != base) begin
            n_err++; $display("FAIL stall_hold: seen %b unstable %b accepted %0d want 1 0 0",
                              seen, unstable, got_a.size() - base);
        end
        leaf_r_a = 1'b1;
        wait_done_a(ok);
        miss[9] = 1'b0;
        n_cmp++;
        if (!ok || got_a.size() != base + 2) begin
            n_err++; $display("FAIL lmiss_count: done %b leaves %0d want 1 2", ok, got_a.size() - base);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (base + i >= got_a.size() || got_a[base+i] !== DW'(exp_l[i])) begin
                n_err++; $display("FAIL lmiss_leaf%0d: leaf missing or wrong, want %0d", i, exp_l[i]);
            end
        end
        n_cmp++;
        if (nv_a !== 16'd5) begin n_err++; $display("FAIL lmiss_nv: got %0d want 5", nv_a); end
    endtask

    task automatic test_latency_tree();
        int base = got_b.size();
        bit ok;
        bd_b = 4;
        go_b(0);
        wait_done_b(ok);
        n_cmp++;
        if (!ok || got_b.size() != base + 4 || nv_b !== 16'd7 || ovf_b !== 1'b0) begin
            n_err++; $display("FAIL lat_tree: done %b leaves %0d nv %0d ovf %b want 1 4 7 0",
                              ok, got_b.size() - base, nv_b, ovf_b);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (base + i >= got_b.size() || got_b[base+i] !== DW'(i)) begin
                n_err++; $display("FAIL lat_leaf%0d: leaf missing or wrong, want %0d", i, i);
            end
        end
    endtask

    task automatic test_overflow();
        int base = got_b.size();
        int h0;
        bit ok;
        go_b(72);
        wait_done_b(ok);
        n_cmp++;
        if (!ok || ovf_b !== 1'b1 || nv_b !== 16'd3 || got_b.size() != base) begin
            n_err++; $display("FAIL ovf_set: done %b ovf %b nv %0d leaves %0d want 1 1 3 0",
                              ok, ovf_b, nv_b, got_b.size() - base);
        end
        h0 = hs_b;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (hs_b != h0 || ovf_b !== 1'b1 || busy_b !== 1'b0) begin
            n_err++; $display("FAIL ovf_quiet: new reqs %0d ovf %b busy %b want 0 1 0",
                              hs_b - h0, ovf_b, busy_b);
        end
        go_b(63);
        n_cmp++;
        if (ovf_b !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf_b); end
        wait_done_b(ok);
        n_cmp++;
        if (!ok || got_b.size() != base + 1 || got_b[base] !== 32'd5) begin
            n_err++; $display("FAIL ovf_restart: done %b leaves %0d want 1 one leaf 5",
                              ok, got_b.size() - base);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int base;
        int d0;
        bit ok, seen;
        go_b(0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rd_b;
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (!seen || {busy_b, done_b, ovf_b, rd_b, breq_v_b, leaf_v_b} !== 6'b0 ||
            {addr_b, breq_p_b, leaf_tri_b, nv_b, st_b} !== '0) begin
            n_err++; $display("FAIL midrst_out: fetch seen %b ctl %b nv %0d st %0d want 1 0 0 0",
                              seen, {busy_b, done_b, ovf_b, rd_b, breq_v_b, leaf_v_b}, nv_b, st_b);
        end
        @(negedge clk);
        reset = 1'b0;
        d0 = dcnt_b;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (dcnt_b != d0 || busy_b !== 1'b0) begin
            n_err++; $display("FAIL midrst_quiet: pulses %0d busy %b want 0 0", dcnt_b - d0, busy_b);
        end
        base = got_b.size();
        go_b(0);
        wait_done_b(ok);
        n_cmp++;
        if (!ok || got_b.size() != base + 4 || nv_b !== 16'd7) begin
            n_err++; $display("FAIL midrst_again: done %b leaves %0d nv %0d want 1 4 7",
                              ok, got_b.size() - base, nv_b);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (base + i >= got_b.size() || got_b[base+i] !== DW'(i)) begin
                n_err++; $display("FAIL midrst_leaf%0d: leaf missing or wrong, want %0d", i, i);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        root_a = '0; root_b = '0;
        leaf_r_a = 1'b1; leaf_r_b = 1'b1;
        bd_a = 0; bd_b = 0;
        init_mem();
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_single_leaf();
        test_root_miss();
        test_full_tree();
        test_left_miss_stall();
        test_latency_tree();
        test_overflow();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bvh_traverse_ctrl.md
Name: bvh_traverse_ctrl

Overview:
Parametrised BVH traversal controller for the ray tracing pipeline. It walks the scene BVH in scene memory with an explicit depth-first stack of configurable depth. For each node it delegates the ray/AABB slab test to an external box-intersect unit over a valid/ready handshake. It streams every hit leaf's triangle index to the downstream triangle tester, and signals completion or stack overflow.

Parameters:
ADDR_W, 18, scene memory word-address width
DATA_W, 32, scene memory word width (Q15.16 coordinates, uint indices)
STACK_DEPTH, 32, traversal stack entries (power of two, >=2)
MEM_LAT, 1, fixed scene memory read latency in cycles (>=1)
NODE_WORDS, 9, node stride: words 0-5 bbox min/max xyz, 6 tri index, 7 left ptr, 8 right ptr

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin traversal; sampled only in IDLE
root_ptr  in  ADDR_W  word address of root node, latched on start
busy  out  1  high from the cycle after an accepted start until DONE/ERR exits
done  out  1  one-cycle pulse: traversal complete
overflow  out  1  sticky error: push attempted with stack full; cleared on next accepted start
mem_rd_en  out  1  scene memory read strobe
mem_addr  out  ADDR_W  scene memory read address
mem_rdata  in  DATA_W  read data, valid exactly MEM_LAT cycles after mem_rd_en
box_req_valid  out  1  request box test of node box_req_ptr
box_req_ready  in  1  box unit accepts request
box_req_ptr  out  ADDR_W  node address under test
box_rsp_valid  in  1  box result valid (one-cycle pulse)
box_hit  in  1  ray intersects node bbox (qualified by box_rsp_valid)
leaf_valid  out  1  leaf triangle index available
leaf_ready  in  1  downstream accepts leaf
leaf_tri  out  DATA_W  triangle index of hit leaf
nodes_visited  out  16  box tests issued this traversal, saturating at 16'hFFFF

Behaviour:
- Reset: state IDLE; busy, done, overflow, mem_rd_en, box_req_valid, leaf_valid = 0; mem_addr, box_req_ptr, leaf_tri, nodes_visited = 0; stack pointer sp = 0.
- States: IDLE, BOX_REQ, BOX_WAIT, FETCH, DECIDE, EMIT, POP, DONE, ERR.
- IDLE: on start, latch cur = root_ptr, sp = 0, nodes_visited = 0, overflow = 0 -> BOX_REQ.
- BOX_REQ: box_req_valid = 1, box_req_ptr = cur, held stable until box_req_ready. Handshake cycle: nodes_visited++ (saturating) -> BOX_WAIT.
- BOX_WAIT: on box_rsp_valid: hit -> FETCH; miss -> POP. A box_rsp_valid arriving in the handshake cycle is ignored.
- FETCH: issue reads cur+6, cur+7, cur+8 on three consecutive cycles (mem_rd_en = 1). Capture tri/left/right MEM_LAT cycles after each issue. Move to DECIDE when the third word is captured. Total FETCH cycles = 3 + MEM_LAT.
- DECIDE, leaf (tri != all-ones): leaf_tri = tri -> EMIT.
- DECIDE, internal node (tri == all-ones):
  - sp == STACK_DEPTH: overflow = 1 -> ERR.
  - otherwise push right (stack[sp] = right, sp++), cur = left -> BOX_REQ.
- EMIT: leaf_valid = 1, leaf_tri held stable until leaf_ready. Handshake cycle -> POP. No leaf is dropped or duplicated.
- POP: sp == 0 -> DONE; else sp--, cur = stack[sp-1] -> BOX_REQ.
- DONE: done = 1 for one cycle, busy = 0 -> IDLE.
- ERR: done = 1 for one cycle, busy = 0, overflow stays set -> IDLE.
- start is ignored while busy. At most one box request and one leaf are outstanding at any time.
- Reset mid-operation returns all state to reset values within the reset assertion, including any pending memory data, which is discarded. No done pulse follows.
- nodes_visited holds its final value after DONE/ERR until the next accepted start.

Test Plan:
- Single leaf root (tri = 5), box hit, leaf_ready tied 1 -> one leaf_tri = 5, done pulse, nodes_visited = 1, overflow = 0.
- Root box miss -> no leaf_valid; done 1 cycle after POP; nodes_visited = 1.
- 3-level complete tree, all boxes hit, leaves tri 0..3 left-to-right -> leaf order 0,1,2,3; nodes_visited = 7; max sp = 2.
- Same tree, left subtree miss -> leaves 2,3 only; nodes_visited = 5. Hold leaf_ready low 10 cycles on first leaf -> leaf_tri stable, single acceptance.
- STACK_DEPTH = 2, left-degenerate chain of depth 4 -> overflow = 1 at third push, done pulse, no further box requests. Next start clears overflow.
- MEM_LAT = 3 with box_req_ready delayed 4 cycles; assert reset mid-FETCH -> all outputs 0. A fresh start then traverses correctly.
